// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one single-port data memory between the core and a debug port.
// Optional debug burst lock is built when DMEM_ARB_BURST_EN is defined.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wd,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rd,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wd,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rd,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  typedef enum logic {
    PRI_CORE = 1'b0,
    PRI_DBG  = 1'b1
  } state_t;

  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_DBG  = 1'b1;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_core_gnt;
  logic   w_dbg_gnt;
  logic   w_issue;
  logic   w_sel_we;
  logic   w_dbg_wins_tie;
  logic   w_dbg_locked;
  logic   r_rsp_valid;
  logic   r_rsp_owner;

`ifdef DMEM_ARB_BURST_EN
  localparam int unsigned     HOLD_W   = 4;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              w_force_core;

  // A saturated lock streak hands the next tie to the core.
  assign w_force_core   = (r_hold_cnt >= HOLD_MAX);
  assign w_dbg_wins_tie = (r_state == PRI_DBG) && !w_force_core;
  assign w_dbg_locked   = dbg_lock;

  always_comb begin
    w_hold_nxt = r_hold_cnt;
    if (w_core_gnt || !dbg_lock) begin
      w_hold_nxt = '0;
    end else if (w_dbg_gnt && (r_hold_cnt < HOLD_MAX)) begin
      w_hold_nxt = r_hold_cnt + HOLD_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_hold_cnt <= '0;
    end else begin
      r_hold_cnt <= w_hold_nxt;
    end
  end
`else
  logic w_unused;

  assign w_unused       = dbg_lock | (MAX_HOLD > 32'd15);
  assign w_dbg_wins_tie = (r_state == PRI_DBG);
  assign w_dbg_locked   = 1'b0;
`endif

  // Grants are held low during reset so every output reads 0.
  assign w_core_gnt = reset && core_req && (!dbg_req || !w_dbg_wins_tie);
  assign w_dbg_gnt  = reset && dbg_req && (!core_req || w_dbg_wins_tie);
  assign w_issue    = w_core_gnt || w_dbg_gnt;
  assign w_sel_we   = w_dbg_gnt ? dbg_we : core_we;

  assign core_stall = reset && core_req && !w_core_gnt;
  assign dbg_gnt    = w_dbg_gnt;

  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (w_core_gnt) begin
      mem_en   = 1'b1;
      mem_we   = core_we;
      mem_addr = core_addr;
      mem_wd   = core_wd;
    end else if (w_dbg_gnt) begin
      mem_en   = 1'b1;
      mem_we   = dbg_we;
      mem_addr = dbg_addr;
      mem_wd   = dbg_wd;
    end
  end

  // Round-robin: the requester just served loses the next tie, unless debug holds a burst lock.
  always_comb begin
    w_state_nxt = r_state;
    if (w_core_gnt) begin
      w_state_nxt = PRI_DBG;
    end else if (w_dbg_gnt) begin
      w_state_nxt = w_dbg_locked ? PRI_DBG : PRI_CORE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= PRI_CORE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_owner <= OWNER_CORE;
    end else begin
      r_rsp_valid <= w_issue && !w_sel_we;
      r_rsp_owner <= w_dbg_gnt ? OWNER_DBG : OWNER_CORE;
    end
  end

  assign core_rvalid = r_rsp_valid && (r_rsp_owner == OWNER_CORE);
  assign dbg_rvalid  = r_rsp_valid && (r_rsp_owner == OWNER_DBG);
  assign core_rd     = core_rvalid ? mem_rd : '0;
  assign dbg_rd      = dbg_rvalid ? mem_rd : '0;

  a_one_grant : assert property (@(posedge clock) disable iff (!reset)
    !(w_core_gnt && w_dbg_gnt));

  a_one_rvalid : assert property (@(posedge clock) disable iff (!reset)
    !(core_rvalid && dbg_rvalid));

  a_read_resp : assert property (@(posedge clock) disable iff (!reset)
    (w_issue && !w_sel_we) |=> (core_rvalid || dbg_rvalid));

endmodule
